// File: rtl/fib_tree_walker.sv
// FIB binary-search-tree lookup engine: walks node records from node storage and reports hit/miss.
// Optional depth guard against pointer loops: define FIB_WALK_DEPTH_GUARD_EN.
module fib_tree_walker #(
  parameter  int unsigned WORD_SIZE    = 16,
  parameter  int unsigned POINTER_SIZE = 16,
  parameter  int unsigned MAX_DEPTH    = 16,
  localparam int unsigned DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    lookup_valid_in,
  output logic                    lookup_ready_out,
  input  logic [WORD_SIZE-1:0]    lookup_key_in,
  input  logic [POINTER_SIZE-1:0] root_pointer_in,
  output logic                    node_rd_en_out,
  output logic [POINTER_SIZE-1:0] node_addr_out,
  input  logic [WORD_SIZE-1:0]    node_data_word_in,
  input  logic                    node_valid_bit_in,
  input  logic [POINTER_SIZE-1:0] left_pointer_in,
  input  logic [POINTER_SIZE-1:0] right_pointer_in,
  input  logic                    left_pointer_valid_bit_in,
  input  logic                    right_pointer_valid_bit_in,
  output logic                    result_valid_out,
  input  logic                    result_ready_in,
  output logic                    result_hit_out,
  output logic [POINTER_SIZE-1:0] result_pointer_out,
  output logic [DEPTH_W-1:0]      result_depth_out,
  output logic                    result_error_out
);

  localparam logic [DEPTH_W-1:0] DEPTH_SAT   = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                    hit;
    logic [POINTER_SIZE-1:0] ptr;
    logic [DEPTH_W-1:0]      depth;
    logic                    err;
  } result_t;

  state_t                  state_q, state_d;
  logic [WORD_SIZE-1:0]    key_q, key_d;
  logic [POINTER_SIZE-1:0] ptr_q, ptr_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  result_t                 res_q, res_d;

  logic                    ready_q;
  logic                    rd_en_q;
  logic [POINTER_SIZE-1:0] addr_q;
  logic                    res_valid_q;

  logic                    go_left;
  logic [POINTER_SIZE-1:0] child_ptr;
  logic                    child_valid;
  logic                    at_depth_limit;

  // Child selection from the node record currently on the storage bus
  assign go_left     = (key_q < node_data_word_in);
  assign child_ptr   = go_left ? left_pointer_in : right_pointer_in;
  assign child_valid = go_left ? left_pointer_valid_bit_in : right_pointer_valid_bit_in;

`ifdef FIB_WALK_DEPTH_GUARD_EN
  assign at_depth_limit = (depth_q == DEPTH_LIMIT);
`else
  assign at_depth_limit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and walk datapath
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ptr_d     = ptr_q;
    depth_d   = depth_q;
    res_d.hit   = 1'b0;
    res_d.ptr   = ptr_q;
    res_d.depth = depth_q;
    res_d.err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (lookup_valid_in) begin
          key_d   = lookup_key_in;
          ptr_d   = root_pointer_in;
          depth_d = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        depth_d = (depth_q == DEPTH_SAT) ? depth_q : depth_q + DEPTH_W'(1);
        state_d = CHECK;
      end

      CHECK: begin
        if (!node_valid_bit_in) begin
          state_d = DONE;
        end else if (key_q == node_data_word_in) begin
          res_d.hit = 1'b1;
          state_d   = DONE;
        end else if (!child_valid) begin
          state_d = DONE;
        end else if (at_depth_limit) begin
          // A further descent at the limit is treated as a pointer loop
          res_d.err = 1'b1;
          state_d   = DONE;
        end else begin
          ptr_d   = child_ptr;
          state_d = FETCH;
        end
      end

      DONE: begin
        if (result_ready_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Walk context and registered outputs, all derived from the next state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_q       <= '0;
      ptr_q       <= '0;
      depth_q     <= '0;
      ready_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      key_q       <= key_d;
      ptr_q       <= ptr_d;
      depth_q     <= depth_d;
      ready_q     <= (state_d == IDLE);
      rd_en_q     <= (state_d == FETCH);
      res_valid_q <= (state_d == DONE);
      if (state_d == FETCH) begin
        addr_q <= ptr_d;
      end
      // Result fields only change when a new lookup completes
      if ((state_q == CHECK) && (state_d == DONE)) begin
        res_q <= res_d;
      end
    end
  end

  assign lookup_ready_out   = ready_q;
  assign node_rd_en_out     = rd_en_q;
  assign node_addr_out      = addr_q;
  assign result_valid_out   = res_valid_q;
  assign result_hit_out     = res_q.hit;
  assign result_pointer_out = res_q.ptr;
  assign result_depth_out   = res_q.depth;
  assign result_error_out   = res_q.err;

endmodule

// File: tb/tb_fib_tree_walker.sv
// Bench for fib_tree_walker: node storage model, reference tree walk, directed and random lookups.
// Runs with or without FIB_WALK_DEPTH_GUARD_EN; MAX_DEPTH is set to 4.
module tb_fib_tree_walker;

  localparam int unsigned WS  = 16;
  localparam int unsigned PS  = 16;
  localparam int unsigned MD  = 4;
  localparam int unsigned DW  = $clog2(MD + 1);
  localparam int          SAT = (1 << DW) - 1;
`ifdef FIB_WALK_DEPTH_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          lookup_valid_in;
  logic          lookup_ready_out;
  logic [WS-1:0] lookup_key_in;
  logic [PS-1:0] root_pointer_in;
  logic          node_rd_en_out;
  logic [PS-1:0] node_addr_out;
  logic [WS-1:0] node_data_word_in;
  logic          node_valid_bit_in;
  logic [PS-1:0] left_pointer_in;
  logic [PS-1:0] right_pointer_in;
  logic          left_pointer_valid_bit_in;
  logic          right_pointer_valid_bit_in;
  logic          result_valid_out;
  logic          result_ready_in;
  logic          result_hit_out;
  logic [PS-1:0] result_pointer_out;
  logic [DW-1:0] result_depth_out;
  logic          result_error_out;

  always #5 clk_in = ~clk_in;

  fib_tree_walker #(.WORD_SIZE(WS), .POINTER_SIZE(PS), .MAX_DEPTH(MD)) dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .lookup_valid_in            (lookup_valid_in),
    .lookup_ready_out           (lookup_ready_out),
    .lookup_key_in              (lookup_key_in),
    .root_pointer_in            (root_pointer_in),
    .node_rd_en_out             (node_rd_en_out),
    .node_addr_out              (node_addr_out),
    .node_data_word_in          (node_data_word_in),
    .node_valid_bit_in          (node_valid_bit_in),
    .left_pointer_in            (left_pointer_in),
    .right_pointer_in           (right_pointer_in),
    .left_pointer_valid_bit_in  (left_pointer_valid_bit_in),
    .right_pointer_valid_bit_in (right_pointer_valid_bit_in),
    .result_valid_out           (result_valid_out),
    .result_ready_in            (result_ready_in),
    .result_hit_out             (result_hit_out),
    .result_pointer_out         (result_pointer_out),
    .result_depth_out           (result_depth_out),
    .result_error_out           (result_error_out)
  );

  // Node storage: one-cycle registered read, plus a log of every strobed address
  logic [WS-1:0] m_word  [0:255];
  logic          m_valid [0:255];
  logic [PS-1:0] m_left  [0:255];
  logic [PS-1:0] m_right [0:255];
  logic          m_lv    [0:255];
  logic          m_rv    [0:255];
  logic [PS-1:0] addr_log[$];

  logic [WS-1:0] rd_word  = '0;
  logic          rd_valid = 1'b0;
  logic [PS-1:0] rd_left  = '0;
  logic [PS-1:0] rd_right = '0;
  logic          rd_lv    = 1'b0;
  logic          rd_rv    = 1'b0;

  always @(posedge clk_in) begin
    if (node_rd_en_out === 1'b1) begin
      rd_word  <= m_word [node_addr_out[7:0]];
      rd_valid <= m_valid[node_addr_out[7:0]];
      rd_left  <= m_left [node_addr_out[7:0]];
      rd_right <= m_right[node_addr_out[7:0]];
      rd_lv    <= m_lv   [node_addr_out[7:0]];
      rd_rv    <= m_rv   [node_addr_out[7:0]];
      addr_log.push_back(node_addr_out);
    end
  end

  assign node_data_word_in          = rd_word;
  assign node_valid_bit_in          = rd_valid;
  assign left_pointer_in            = rd_left;
  assign right_pointer_in           = rd_right;
  assign left_pointer_valid_bit_in  = rd_lv;
  assign right_pointer_valid_bit_in = rd_rv;

  int tests = 0;
  int fails = 0;

  // Reference expectations
  bit            exp_hit, exp_err;
  logic [PS-1:0] exp_ptr;
  logic [DW-1:0] exp_depth;
  int            exp_reads, exp_lat;
  logic [PS-1:0] exp_path[$];

  // Observations from the last lookup
  bit            obs_timeout;
  logic          obs_hit, obs_err;
  logic [PS-1:0] obs_ptr;
  logic [DW-1:0] obs_depth;
  int            obs_lat;

  int alloc;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      m_word[i] = '0; m_valid[i] = 1'b0; m_left[i] = '0; m_right[i] = '0;
      m_lv[i] = 1'b0; m_rv[i] = 1'b0;
    end
  endtask

  task automatic set_node(input int a, input logic [WS-1:0] w, input logic v,
                          input logic [PS-1:0] l, input logic lv,
                          input logic [PS-1:0] r, input logic rv);
    m_word[a] = w; m_valid[a] = v; m_left[a] = l; m_lv[a] = lv; m_right[a] = r; m_rv[a] = rv;
  endtask

  // Plain BST insert used to build random trees rooted at 0x20
  task automatic bst_insert(input logic [WS-1:0] k);
    int p;
    int a;
    if (!m_valid[8'h20]) begin
      set_node(32'h20, k, 1'b1, '0, 1'b0, '0, 1'b0);
      alloc = 1;
      return;
    end
    p = 32'h20;
    for (int i = 0; i < 64; i++) begin
      if (k == m_word[p]) return;
      a = 32'h20 + alloc;
      if (k < m_word[p]) begin
        if (m_lv[p]) p = int'(m_left[p]);
        else begin
          set_node(a, k, 1'b1, '0, 1'b0, '0, 1'b0);
          m_left[p] = PS'(a); m_lv[p] = 1'b1; alloc++;
          return;
        end
      end else begin
        if (m_rv[p]) p = int'(m_right[p]);
        else begin
          set_node(a, k, 1'b1, '0, 1'b0, '0, 1'b0);
          m_right[p] = PS'(a); m_rv[p] = 1'b1; alloc++;
          return;
        end
      end
    end
  endtask

  // Reference: follow the tree from the root as the lookup rules describe
  task automatic ref_walk(input logic [WS-1:0] key, input logic [PS-1:0] root);
    logic [PS-1:0] p;
    logic [PS-1:0] child;
    logic          cv;
    p = root; exp_reads = 0; exp_hit = 0; exp_err = 0;
    exp_path.delete();
    for (int i = 0; i < 64; i++) begin
      exp_reads++;
      exp_path.push_back(p);
      if (!m_valid[p[7:0]]) break;
      if (key == m_word[p[7:0]]) begin exp_hit = 1; break; end
      if (key < m_word[p[7:0]]) begin child = m_left[p[7:0]];  cv = m_lv[p[7:0]]; end
      else                      begin child = m_right[p[7:0]]; cv = m_rv[p[7:0]]; end
      if (!cv) break;
      if (GUARD && exp_reads == int'(MD)) begin exp_err = 1; break; end
      p = child;
    end
    exp_ptr   = p;
    exp_depth = (exp_reads > SAT) ? DW'(SAT) : DW'(exp_reads);
    exp_lat   = 2 * exp_reads + 1;
  endtask

  // Issue a lookup and wait (bounded) for result_valid_out; latency counts the accept edge as 1
  task automatic start_and_wait(input logic [WS-1:0] key, input logic [PS-1:0] root);
    int n;
    obs_timeout = 0;
    n = 0;
    @(negedge clk_in);
    while (lookup_ready_out !== 1'b1 && n < 50) begin @(negedge clk_in); n++; end
    if (lookup_ready_out !== 1'b1) obs_timeout = 1;
    addr_log.delete();
    lookup_key_in = key; root_pointer_in = root; lookup_valid_in = 1'b1;
    @(posedge clk_in);
    #1 lookup_valid_in = 1'b0;
    obs_lat = 1;
    while (result_valid_out !== 1'b1 && obs_lat < 300) begin
      @(posedge clk_in); #1; obs_lat++;
    end
    if (result_valid_out !== 1'b1) obs_timeout = 1;
    obs_hit = result_hit_out; obs_ptr = result_pointer_out;
    obs_depth = result_depth_out; obs_err = result_error_out;
  endtask

  task automatic release_result();
    @(negedge clk_in);
    result_ready_in = 1'b1;
    @(posedge clk_in);
    #1 result_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    tests++; if (lookup_ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", lookup_ready_out); end
    tests++; if (node_rd_en_out !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", node_rd_en_out); end
    tests++; if (node_addr_out !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", node_addr_out); end
    tests++; if (result_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", result_valid_out); end
    tests++; if ({result_hit_out, result_error_out} !== 2'b00) begin fails++; $display("FAIL reset_hit_err: got %b%b want 00", result_hit_out, result_error_out); end
    tests++; if (result_pointer_out !== '0) begin fails++; $display("FAIL reset_ptr: got %h want 0", result_pointer_out); end
    tests++; if (result_depth_out !== '0) begin fails++; $display("FAIL reset_depth: got %0d want 0", result_depth_out); end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    tests++; if (lookup_ready_out !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", lookup_ready_out); end
  endtask

  task automatic build_basic_tree();
    clear_mem();
    set_node(0, 16'h0050, 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1);
    set_node(1, 16'h0020, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    set_node(2, 16'h0080, 1'b1, 16'h0000, 1'b0, 16'h0004, 1'b1);
    set_node(4, 16'h0090, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_basic_tree();
    logic [WS-1:0] keys   [4] = '{16'h0050, 16'h0080, 16'h0030, 16'h0090};
    bit            hits   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [PS-1:0] ptrs   [4] = '{16'h0000, 16'h0002, 16'h0001, 16'h0004};
    int            depths [4] = '{1, 2, 2, 3};
    logic [DW-1:0] dep;
    build_basic_tree();
    for (int i = 0; i < 4; i++) begin
      dep = DW'(depths[i]);
      start_and_wait(keys[i], 16'h0000);
      tests++; if (obs_timeout) begin fails++; $display("FAIL basic_timeout[%0d]: got timeout want result", i); end
      tests++; if (obs_hit !== hits[i]) begin fails++; $display("FAIL basic_hit[%0d]: got %b want %b", i, obs_hit, hits[i]); end
      tests++; if (obs_ptr !== ptrs[i]) begin fails++; $display("FAIL basic_ptr[%0d]: got %h want %h", i, obs_ptr, ptrs[i]); end
      tests++; if (obs_depth !== dep) begin fails++; $display("FAIL basic_depth[%0d]: got %0d want %0d", i, obs_depth, dep); end
      tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL basic_err[%0d]: got %b want 0", i, obs_err); end
      tests++; if (obs_lat != 2 * depths[i] + 1) begin fails++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, obs_lat, 2 * depths[i] + 1); end
      tests++; if (addr_log.size() != depths[i]) begin fails++; $display("FAIL basic_reads[%0d]: got %0d want %0d", i, addr_log.size(), depths[i]); end
      if (i == 1 && addr_log.size() == 2) begin
        tests++; if (addr_log[0] !== 16'h0000 || addr_log[1] !== 16'h0002) begin
          fails++; $display("FAIL basic_addr_seq: got %h,%h want 0000,0002", addr_log[0], addr_log[1]);
        end
      end
      release_result();
    end
  endtask

  task automatic test_invalid_root_hold();
    clear_mem();
    set_node(16, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
    set_node(0, 16'h0001, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    result_ready_in = 1'b0;
    start_and_wait(16'h0001, 16'h0010);
    tests++; if (obs_timeout || obs_hit !== 1'b0 || obs_ptr !== 16'h0010 || obs_depth !== DW'(1)) begin
      fails++; $display("FAIL invalid_root: got to=%0d hit=%b ptr=%h depth=%0d want to=0 hit=0 ptr=0010 depth=1",
                        obs_timeout, obs_hit, obs_ptr, obs_depth);
    end
    // Hold the result; a new request presented meanwhile must be ignored
    for (int c = 0; c < 4; c++) begin
      lookup_valid_in = 1'b1; lookup_key_in = 16'h0001; root_pointer_in = 16'h0000;
      @(posedge clk_in); #1;
      tests++; if (result_valid_out !== 1'b1 || lookup_ready_out !== 1'b0) begin
        fails++; $display("FAIL hold_handshake[%0d]: got valid=%b ready=%b want valid=1 ready=0", c, result_valid_out, lookup_ready_out);
      end
      tests++; if (result_hit_out !== 1'b0 || result_pointer_out !== 16'h0010 || result_depth_out !== DW'(1)) begin
        fails++; $display("FAIL hold_stable[%0d]: got hit=%b ptr=%h depth=%0d want 0/0010/1", c, result_hit_out, result_pointer_out, result_depth_out);
      end
    end
    lookup_valid_in = 1'b0;
    tests++; if (addr_log.size() != 1) begin fails++; $display("FAIL ignore_request: got %0d reads want 1", addr_log.size()); end
    release_result();
    tests++; if (lookup_ready_out !== 1'b1 || result_valid_out !== 1'b0 || result_pointer_out !== 16'h0010) begin
      fails++; $display("FAIL after_release: got ready=%b valid=%b ptr=%h want 1/0/0010", lookup_ready_out, result_valid_out, result_pointer_out);
    end
  endtask

  task automatic test_depth_limit();
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      set_node(64 + i, WS'(10 * (i + 1)), 1'b1, '0, 1'b0, PS'(65 + i), (i < 9));
    end
    ref_walk(16'h00FF, 16'h0040);
    start_and_wait(16'h00FF, 16'h0040);
    tests++; if (obs_timeout) begin fails++; $display("FAIL chain_timeout: got timeout want result"); end
    tests++; if (obs_hit !== 1'b0 || obs_err !== exp_err || obs_ptr !== exp_ptr) begin
      fails++; $display("FAIL chain_result: got hit=%b err=%b ptr=%h want 0/%b/%h", obs_hit, obs_err, obs_ptr, exp_err, exp_ptr);
    end
    tests++; if (obs_depth !== exp_depth || addr_log.size() != exp_reads) begin
      fails++; $display("FAIL chain_depth: got depth=%0d reads=%0d want %0d/%0d", obs_depth, addr_log.size(), exp_depth, exp_reads);
    end
    release_result();
`ifdef FIB_WALK_DEPTH_GUARD_EN
    set_node(3, 16'h0010, 1'b1, '0, 1'b0, 16'h0003, 1'b1);
    start_and_wait(16'h00FF, 16'h0003);
    tests++; if (obs_timeout || obs_hit !== 1'b0 || obs_err !== 1'b1 || obs_depth !== DW'(4) || obs_ptr !== 16'h0003) begin
      fails++; $display("FAIL self_loop: got to=%0d hit=%b err=%b depth=%0d ptr=%h want 0/0/1/4/0003",
                        obs_timeout, obs_hit, obs_err, obs_depth, obs_ptr);
    end
    tests++; if (addr_log.size() != 4) begin fails++; $display("FAIL self_loop_reads: got %0d want 4", addr_log.size()); end
    release_result();
`endif
  endtask

  task automatic test_reset_mid_walk();
    bit seen;
    build_basic_tree();
    @(negedge clk_in);
    lookup_key_in = 16'h0090; root_pointer_in = 16'h0000; lookup_valid_in = 1'b1;
    @(posedge clk_in);
    #1 lookup_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    tests++; if (node_rd_en_out !== 1'b0 || result_valid_out !== 1'b0 || lookup_ready_out !== 1'b0) begin
      fails++; $display("FAIL midreset_outputs: got rd=%b valid=%b ready=%b want 0/0/0", node_rd_en_out, result_valid_out, lookup_ready_out);
    end
    @(posedge clk_in); #1;
    tests++; if (lookup_ready_out !== 1'b1) begin fails++; $display("FAIL midreset_idle: got ready=%b want 1", lookup_ready_out); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_in); #1;
      if (result_valid_out !== 1'b0 || node_rd_en_out !== 1'b0) seen = 1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midreset_no_result: got activity want none"); end
    start_and_wait(16'h0090, 16'h0000);
    tests++; if (obs_timeout || obs_hit !== 1'b1 || obs_ptr !== 16'h0004 || obs_depth !== DW'(3) || obs_lat != 7) begin
      fails++; $display("FAIL midreset_relookup: got to=%0d hit=%b ptr=%h depth=%0d lat=%0d want 0/1/0004/3/7",
                        obs_timeout, obs_hit, obs_ptr, obs_depth, obs_lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    build_basic_tree();
    result_ready_in = 1'b1;
    start_and_wait(16'h0050, 16'h0000);
    @(posedge clk_in); #1;
    tests++; if (result_valid_out !== 1'b0 || lookup_ready_out !== 1'b1) begin
      fails++; $display("FAIL b2b_return: got valid=%b ready=%b want 0/1", result_valid_out, lookup_ready_out);
    end
    start_and_wait(16'h0020, 16'h0000);
    tests++; if (obs_timeout || obs_hit !== 1'b1 || obs_ptr !== 16'h0001 || obs_lat != 5) begin
      fails++; $display("FAIL b2b_second: got to=%0d hit=%b ptr=%h lat=%0d want 0/1/0001/5", obs_timeout, obs_hit, obs_ptr, obs_lat);
    end
    @(posedge clk_in); #1;
    result_ready_in = 1'b0;
    tests++; if (lookup_ready_out !== 1'b1) begin fails++; $display("FAIL b2b_idle: got ready=%b want 1", lookup_ready_out); end
  endtask

  task automatic test_random();
    logic [WS-1:0] ins[$];
    logic [WS-1:0] k;
    bit            bad;
    clear_mem();
    alloc = 0;
    for (int i = 0; i < 15; i++) begin
      k = WS'($urandom_range(0, 255));
      ins.push_back(k);
      bst_insert(k);
    end
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) k = ins[$urandom_range(0, ins.size() - 1)];
      else                           k = WS'($urandom_range(0, 300));
      ref_walk(k, 16'h0020);
      start_and_wait(k, 16'h0020);
      bad = (addr_log.size() != exp_path.size());
      if (!bad) for (int j = 0; j < exp_path.size(); j++) if (addr_log[j] !== exp_path[j]) bad = 1;
      tests++; if (obs_timeout || obs_hit !== exp_hit || obs_ptr !== exp_ptr || obs_depth !== exp_depth ||
                   obs_err !== exp_err || obs_lat != exp_lat || bad) begin
        fails++; $display("FAIL random[%0d] key=%h: got to=%0d hit=%b ptr=%h depth=%0d err=%b lat=%0d path_bad=%0d want hit=%b ptr=%h depth=%0d err=%b lat=%0d",
                          t, k, obs_timeout, obs_hit, obs_ptr, obs_depth, obs_err, obs_lat, bad,
                          exp_hit, exp_ptr, exp_depth, exp_err, exp_lat);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
      release_result();
    end
  endtask

  initial begin
    rst_in = 1'b1;
    lookup_valid_in = 1'b0;
    lookup_key_in = '0;
    root_pointer_in = '0;
    result_ready_in = 1'b0;
    clear_mem();
    test_reset();
    test_basic_tree();
    test_invalid_root_hold();
    test_depth_limit();
    test_reset_mid_walk();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fib_tree_walker.md
# fib_tree_walker

Lookup engine for the FIB binary search tree: accepts a key and a root pointer, walks the tree by reading node records (data word, left/right pointers and their valid bits) from node storage, and reports hit/miss with the matching node pointer. It is the read side of the node storage written by the FIB insert path. It sits between the packet-name hashing stage and the forwarding decision stage.

## Interface
- WORD_SIZE, 16, width of node data word and lookup key
- POINTER_SIZE, 16, width of node pointers and node address
- MAX_DEPTH, 16, maximum nodes visited per lookup (used by depth guard)
- clk_in  input  1  clock, all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- lookup_valid_in  input  1  request present
- lookup_ready_out  output  1  engine idle, can accept request
- lookup_key_in  input  WORD_SIZE  key to search
- root_pointer_in  input  POINTER_SIZE  address of root node
- node_rd_en_out  output  1  node read strobe
- node_addr_out  output  POINTER_SIZE  node address to read
- node_data_word_in  input  WORD_SIZE  node data word, valid 1 cycle after strobe
- node_valid_bit_in  input  1  node holds valid data
- left_pointer_in / right_pointer_in  input  POINTER_SIZE  child pointers
- left_pointer_valid_bit_in / right_pointer_valid_bit_in  input  1  child pointer valid
- result_valid_out  output  1  result available
- result_ready_in  input  1  consumer takes result
- result_hit_out  output  1  key found
- result_pointer_out  output  POINTER_SIZE  address of matching node (last visited node on miss)
- result_depth_out  output  $clog2(MAX_DEPTH+1)  nodes visited
- result_error_out  output  1  lookup aborted by depth guard

## Operation
- States: IDLE, FETCH, CHECK, DONE.
- IDLE: lookup_ready_out=1. On lookup_valid_in: latch key, current pointer <= root_pointer_in, depth <= 0, go FETCH.
- FETCH: node_rd_en_out=1, node_addr_out=current pointer; depth <= depth+1; go CHECK.
- CHECK: node fields sampled this cycle.
  - node_valid_bit_in=0: miss, go DONE.
  - key == data word: hit, result_pointer_out=current pointer, go DONE.
  - key < data word: left valid -> pointer <= left_pointer_in, go FETCH; else miss, go DONE.
  - key > data word: same with right child.
  - Comparison is unsigned, full WORD_SIZE.
- DONE: result_valid_out=1, result fields stable; on result_ready_in go IDLE.
- Result fields hold their value until next lookup reaches DONE.
- rst_in in any state: state <= IDLE, in-flight lookup discarded, no result produced.

## Timing
- Reset values: lookup_ready_out 0 while rst_in=1, 1 the cycle after; node_rd_en_out 0, node_addr_out 0, result_valid_out 0, result_hit_out 0, result_pointer_out 0, result_depth_out 0, result_error_out 0.
- Accept at edge T (valid & ready) -> FETCH at T+1 -> CHECK at T+2.
- Latency accept -> result_valid_out = 2·D+1 cycles, D = nodes visited (root hit: 3).
- Node storage read latency fixed at 1 cycle; node_rd_en_out high exactly one cycle per node.
- lookup_valid_in ignored outside IDLE; no request queueing.
- result_valid_out held until result_ready_in; ready seen in same cycle as DONE entry -> IDLE next cycle, new accept possible the cycle after.
- Throughput: one lookup at a time.

## Configuration
- FIB_WALK_DEPTH_GUARD_EN defined: in CHECK, if depth == MAX_DEPTH and the node is not a hit and a descent would occur, go DONE with result_hit_out=0, result_error_out=1 (protects against pointer loops).
- Undefined: no depth limit; walk until hit or miss; result_error_out tied 0; result_depth_out saturates at all-ones.

## Test plan
- Tree root@0x0000 word 0x0050, left@0x0001 0x0020, right@0x0002 0x0080; key 0x0050 -> hit, pointer 0x0000, depth 1, result_valid 3 cycles after accept.
- Same tree, key 0x0080 -> hit, pointer 0x0002, depth 2, latency 5; node_addr_out sequence 0x0000, 0x0002.
- Key 0x0030 (left leaf has no valid children) -> miss, pointer 0x0001, depth 2, error 0.
- Root node_valid_bit_in=0, key 0x0001 -> miss, depth 1; hold result_ready_in=0 for 4 cycles -> result stable, lookup_ready_out 0 throughout.
- Self-loop: node 0x0003 word 0x0010, right pointer 0x0003 valid, key 0x00FF, MAX_DEPTH=4 with FIB_WALK_DEPTH_GUARD_EN -> miss, error 1, depth 4 after exactly 4 reads.
- Assert rst_in during CHECK of a 3-level walk -> next cycle IDLE, node_rd_en_out 0, no result_valid_out; subsequent lookup completes normally.
